// File: rtl/div_pkg.sv
// Shared constants and state encoding for the 8-by-4 restoring divider.
//   BITS  : divisor/remainder width
//   ITER  : dividend/quotient width, also the number of shift/subtract steps
//   CNT_W : width of the step counter
package div_pkg;

  localparam int unsigned BITS  = 4;
  localparam int unsigned ITER  = 2 * BITS;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  // Controller state encoding
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
//   r        : current partial remainder
//   d_msb    : dividend bit being brought down
//   v        : divisor
//   r_nxt_c  : partial remainder after this step
//   q_bit_c  : quotient bit produced by this step
module div_step
  import div_pkg::*;
(
  input  logic [BITS-1:0] r,
  input  logic            d_msb,
  input  logic [BITS-1:0] v,
  output logic [BITS-1:0] r_nxt_c,
  output logic            q_bit_c
);

  // The shifted value needs one extra bit for the compare; after a successful
  // subtract (or a plain shift) only the low BITS bits are ever reused.
  logic [BITS:0] t_c;

  always_comb begin
    t_c     = {r, d_msb};
    r_nxt_c = BITS'(t_c);
    q_bit_c = 1'b0;
    if (t_c >= {1'b0, v}) begin
      r_nxt_c = BITS'(t_c - {1'b0, v});
      q_bit_c = 1'b1;
    end
  end

endmodule

// File: rtl/tt_um_carlosgs99_div_8by4.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient
// bit per clock, with a start/busy/done handshake.
// Optional feature macro: DIVZERO_FLAG_EN (zero-divisor shortcut + flag port).
//   clk, rst        : clock, synchronous active-high reset
//   io_start        : request, honoured only in IDLE or DONE
//   io_Dividend     : dividend, captured with an accepted start
//   io_Divisor      : divisor, captured with an accepted start
//   io_busy         : high while the iteration runs
//   io_done         : one-cycle pulse when results update
//   io_Quotient     : quotient, held between done pulses
//   io_div_by_zero  : (DIVZERO_FLAG_EN only) last result had a zero divisor
//   io_Remainder    : remainder, held between done pulses
module tt_um_carlosgs99_div_8by4
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            io_start,
  input  logic [ITER-1:0] io_Dividend,
  input  logic [BITS-1:0] io_Divisor,
  output logic            io_busy,
  output logic            io_done,
  output logic [ITER-1:0] io_Quotient,
`ifdef DIVZERO_FLAG_EN
  output logic            io_div_by_zero,
`endif
  output logic [BITS-1:0] io_Remainder
);

  state_t           state_q, state_d;
  logic [ITER-1:0]  d_q, d_d;
  logic [BITS-1:0]  v_q, v_d;
  logic [BITS-1:0]  r_q, r_d;
  logic [ITER-1:0]  q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ITER-1:0]  quo_d;
  logic [BITS-1:0]  rem_d;
  logic             busy_d, done_d;
  logic [BITS-1:0]  r_nxt_c;
  logic             q_bit_c;
`ifdef DIVZERO_FLAG_EN
  logic             dz_q, dz_d;
  logic             flag_d;
`endif

  div_step u_step (
    .r       (r_q),
    .d_msb   (d_q[ITER-1]),
    .v       (v_q),
    .r_nxt_c (r_nxt_c),
    .q_bit_c (q_bit_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    v_d     = v_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quo_d   = io_Quotient;
    rem_d   = io_Remainder;
`ifdef DIVZERO_FLAG_EN
    dz_d    = dz_q;
    flag_d  = io_div_by_zero;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (io_start) begin
          d_d     = io_Dividend;
          v_d     = io_Divisor;
          r_d     = '0;
          q_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef DIVZERO_FLAG_EN
          dz_d    = (io_Divisor == '0);
`endif
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
`ifdef DIVZERO_FLAG_EN
        // Zero divisor: a single cycle in RUN, then publish the fixed result
        if (dz_q) begin
          state_d = DONE;
          quo_d   = '1;
          rem_d   = '0;
          flag_d  = 1'b1;
        end else
`endif
        begin
          d_d   = {d_q[ITER-2:0], 1'b0};
          r_d   = r_nxt_c;
          q_d   = {q_q[ITER-2:0], q_bit_c};
          cnt_d = CNT_W'(cnt_q + 1'b1);
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_d = DONE;
            quo_d   = {q_q[ITER-2:0], q_bit_c};
            rem_d   = r_nxt_c;
`ifdef DIVZERO_FLAG_EN
            flag_d  = 1'b0;
`endif
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Status outputs are registered copies of the upcoming state
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      d_q            <= '0;
      v_q            <= '0;
      r_q            <= '0;
      q_q            <= '0;
      cnt_q          <= '0;
      io_busy        <= 1'b0;
      io_done        <= 1'b0;
      io_Quotient    <= '0;
      io_Remainder   <= '0;
`ifdef DIVZERO_FLAG_EN
      dz_q           <= 1'b0;
      io_div_by_zero <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      d_q            <= d_d;
      v_q            <= v_d;
      r_q            <= r_d;
      q_q            <= q_d;
      cnt_q          <= cnt_d;
      io_busy        <= busy_d;
      io_done        <= done_d;
      io_Quotient    <= quo_d;
      io_Remainder   <= rem_d;
`ifdef DIVZERO_FLAG_EN
      dz_q           <= dz_d;
      io_div_by_zero <= flag_d;
`endif
    end
  end

endmodule
